// File: rtl/load_store_unit.sv
// Load/store unit: one req/gnt/rvalid data-bus transaction per accepted command, with lane steering and load extension.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (reject misaligned half/word accesses instead of force-aligning them).
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_misaligned_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t                state;
    logic [1:0]            offset_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic                  req_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [1:0]            offset_next;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  reject;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_q;
    logic misaligned;

    assign misaligned = (lsu_size_i == SIZE_HALF && lsu_addr_i[0]) ||
                        (lsu_size_i[1] && lsu_addr_i[1:0] != 2'b00);
    assign reject           = misaligned;
    assign lsu_misaligned_o = misaligned_q;
`else
    assign reject           = 1'b0;
    assign lsu_misaligned_o = 1'b0;
`endif

    // Lane selection for the command presented in IDLE; size 2'b11 behaves as a word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        offset_next = lsu_addr_i[1:0];
        be_next     = 4'b1111;
        wdata_next  = lsu_wdata_i;
        case (lsu_size_i)
            SIZE_BYTE: begin
                be_next    = 4'b0001 << offset_next;
                wdata_next = {4{lsu_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
`ifndef LSU_MISALIGN_TRAP_EN
                offset_next = {lsu_addr_i[1], 1'b0};
`endif
                be_next    = 4'b0011 << offset_next;
                wdata_next = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
`ifndef LSU_MISALIGN_TRAP_EN
                offset_next = 2'b00;
`endif
                be_next    = 4'b1111;
                wdata_next = lsu_wdata_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state    <= IDLE;
            offset_q <= 2'b00;
            size_q   <= 2'b00;
            sign_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (reject) begin
`ifdef LSU_MISALIGN_TRAP_EN
                            misaligned_q <= 1'b1;
`endif
                        end else begin
                            state    <= REQ;
                            req_q    <= 1'b1;
                            offset_q <= offset_next;
                            size_q   <= lsu_size_i;
                            sign_q   <= lsu_sign_ext_i;
                            we_q     <= lsu_we_i;
                            be_q     <= be_next;
                            addr_q   <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            wdata_q  <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        state <= WAIT;
                        req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_busy_o   = (state != IDLE);
    assign lsu_rvalid_o = (state == WAIT) && data_rvalid_i;
    assign data_req_o   = req_q;
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted     = data_rdata_i >> {offset_q, 3'b000};
        lsu_rdata_o = '0;
        if (lsu_rvalid_o && !we_q) begin
            case (size_q)
                SIZE_BYTE: lsu_rdata_o = {{(DATA_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]};
                SIZE_HALF: lsu_rdata_o = {{(DATA_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]};
                default:   lsu_rdata_o = shifted;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; the bench plays the data bus with scripted grant/rvalid timing.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_misaligned_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    load_store_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_sign_ext_i   (lsu_sign_ext_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_busy_o       (lsu_busy_o),
        .lsu_rvalid_o     (lsu_rvalid_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_addr_o      (data_addr_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_wdata_o     (data_wdata_o),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // Observations of the most recent transaction.
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        o_we;
    int          o_req_cycles;
    bit          o_stable;
    bit          o_early_rvalid;
    logic        o_req_in_wait;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_busy_at_rv;
    logic        o_busy_after;

    // Drive one command; grant after gnt_wait extra REQ cycles, rvalid in the first WAIT cycle.
    // noisy: keep lsu_req_i high while busy and drive data_rvalid_i during REQ.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_wait, input logic [31:0] rdata, input bit noisy);
        @(negedge clk_i);
        lsu_req_i      = 1'b1;
        lsu_we_i       = we;
        lsu_size_i     = size;
        lsu_sign_ext_i = sign;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
        @(negedge clk_i);
        lsu_req_i      = noisy;
        data_rvalid_i  = noisy;
        data_rdata_i   = 32'h5A5A_5A5A;
        o_req_cycles   = 0;
        o_stable       = 1'b1;
        o_early_rvalid = 1'b0;
        for (int k = 0; k <= gnt_wait; k++) begin
            data_gnt_i = (k == gnt_wait);
            #1;
            if (data_req_o === 1'b1) begin
                if (o_req_cycles == 0) begin
                    o_addr  = data_addr_o;
                    o_be    = data_be_o;
                    o_wdata = data_wdata_o;
                    o_we    = data_we_o;
                end else if (data_addr_o !== o_addr || data_be_o !== o_be ||
                             data_wdata_o !== o_wdata || data_we_o !== o_we) begin
                    o_stable = 1'b0;
                end
                o_req_cycles++;
            end
            if (lsu_rvalid_o !== 1'b0) o_early_rvalid = 1'b1;
            @(negedge clk_i);
        end
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        #1;
        o_req_in_wait = data_req_o;
        o_rvalid      = lsu_rvalid_o;
        o_rdata       = lsu_rdata_o;
        o_busy_at_rv  = lsu_busy_o;
        lsu_req_i     = 1'b0;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        #1;
        o_busy_after  = lsu_busy_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
        lsu_addr_i = '0; lsu_wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        total++;
        if ({lsu_busy_o, data_req_o, data_we_o, lsu_rvalid_o, lsu_misaligned_o} !== 5'b0)
            $display("FAIL reset_ctrl: busy/req/we/rvalid/mis got %b expected 00000",
                     {lsu_busy_o, data_req_o, data_we_o, lsu_rvalid_o, lsu_misaligned_o});
        else passed++;
        total++;
        if (data_addr_o !== 32'h0 || data_be_o !== 4'h0 || data_wdata_o !== 32'h0 || lsu_rdata_o !== 32'h0)
            $display("FAIL reset_data: addr %h be %b wdata %h rdata %h expected all zero",
                     data_addr_o, data_be_o, data_wdata_o, lsu_rdata_o);
        else passed++;
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        total++;
        if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0)
            $display("FAIL idle_after_reset: busy %b req %b expected 0 0", lsu_busy_o, data_req_o);
        else passed++;
    endtask

    task automatic test_lw();
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        total++;
        if (o_req_cycles != 1 || o_early_rvalid || o_rvalid !== 1'b1)
            $display("FAIL lw_latency: req cycles %0d early %0d rvalid@2 %b expected 1 0 1",
                     o_req_cycles, o_early_rvalid, o_rvalid);
        else passed++;
        total++;
        if (o_rdata !== 32'hDEAD_BEEF)
            $display("FAIL lw_rdata: got %h expected deadbeef", o_rdata);
        else passed++;
        total++;
        if (o_addr !== 32'h0000_0100 || o_be !== 4'b1111 || o_we !== 1'b0)
            $display("FAIL lw_bus: addr %h be %b we %b expected 00000100 1111 0", o_addr, o_be, o_we);
        else passed++;
        total++;
        if (o_req_in_wait !== 1'b0 || o_busy_at_rv !== 1'b1 || o_busy_after !== 1'b0)
            $display("FAIL lw_handshake: req_in_wait %b busy_rv %b busy_after %b expected 0 1 0",
                     o_req_in_wait, o_busy_at_rv, o_busy_after);
        else passed++;
    endtask

    task automatic test_sub_word_loads();
        run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h8011_2233, 1'b0);
        total++;
        if (o_be !== 4'b1000 || o_addr !== 32'h0000_0100)
            $display("FAIL lb_bus: be %b addr %h expected 1000 00000100", o_be, o_addr);
        else passed++;
        total++;
        if (o_rdata !== 32'hFFFF_FF80)
            $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata);
        else passed++;
        run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h8011_2233, 1'b0);
        total++;
        if (o_rdata !== 32'h0000_0080)
            $display("FAIL lbu_rdata: got %h expected 00000080", o_rdata);
        else passed++;
        run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1, 32'h8001_1234, 1'b0);
        total++;
        if (o_rdata !== 32'hFFFF_8001 || o_be !== 4'b1100)
            $display("FAIL lh_rdata: got %h be %b expected ffff8001 1100", o_rdata, o_be);
        else passed++;
    endtask

    task automatic test_stores();
        run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 3, 32'hFFFF_FFFF, 1'b0);
        total++;
        if (o_addr !== 32'h0000_0200 || o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_we !== 1'b1)
            $display("FAIL sh_bus: addr %h be %b wdata %h we %b expected 00000200 1100 abcdabcd 1",
                     o_addr, o_be, o_wdata, o_we);
        else passed++;
        total++;
        if (o_req_cycles != 4 || !o_stable)
            $display("FAIL sh_stable: req cycles %0d stable %0d expected 4 1", o_req_cycles, o_stable);
        else passed++;
        total++;
        if (o_busy_at_rv !== 1'b1 || o_rvalid !== 1'b1 || o_rdata !== 32'h0 || o_busy_after !== 1'b0)
            $display("FAIL sh_done: busy %b rvalid %b rdata %h busy_after %b expected 1 1 00000000 0",
                     o_busy_at_rv, o_rvalid, o_rdata, o_busy_after);
        else passed++;
        run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h1234_5677, 0, 32'h0, 1'b0);
        total++;
        if (o_be !== 4'b0010 || o_wdata !== 32'h7777_7777 || o_addr !== 32'h0000_0300)
            $display("FAIL sb_bus: be %b wdata %h addr %h expected 0010 77777777 00000300",
                     o_be, o_wdata, o_addr);
        else passed++;
    endtask

    task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
        bit saw_req;
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_sign_ext_i = 1'b0;
        lsu_addr_i = 32'h0000_0101;
        @(negedge clk_i);
        lsu_req_i = 1'b0;
        #1;
        total++;
        if (lsu_misaligned_o !== 1'b1 || lsu_busy_o !== 1'b0)
            $display("FAIL mis_pulse: misaligned %b busy %b expected 1 0", lsu_misaligned_o, lsu_busy_o);
        else passed++;
        saw_req = (data_req_o !== 1'b0);
        @(negedge clk_i);
        #1;
        saw_req = saw_req || (data_req_o !== 1'b0);
        total++;
        if (lsu_misaligned_o !== 1'b0 || saw_req)
            $display("FAIL mis_after: misaligned %b req_seen %0d expected 0 0", lsu_misaligned_o, saw_req);
        else passed++;
`else
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 0, 32'h1122_3344, 1'b0);
        total++;
        if (o_addr !== 32'h0000_0100 || o_be !== 4'b1111 || o_rdata !== 32'h1122_3344)
            $display("FAIL mis_aligned_lw: addr %h be %b rdata %h expected 00000100 1111 11223344",
                     o_addr, o_be, o_rdata);
        else passed++;
        total++;
        if (lsu_misaligned_o !== 1'b0)
            $display("FAIL mis_tied: misaligned %b expected 0", lsu_misaligned_o);
        else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        bit extra_req;
        run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 0, 32'hCAFE_F00D, 1'b1);
        total++;
        if (o_req_cycles != 1 || o_early_rvalid || o_rvalid !== 1'b1 || o_rdata !== 32'hCAFE_F00D)
            $display("FAIL noisy_txn: req cycles %0d early %0d rvalid %b rdata %h expected 1 0 1 cafef00d",
                     o_req_cycles, o_early_rvalid, o_rvalid, o_rdata);
        else passed++;
        extra_req = (data_req_o !== 1'b0) || (lsu_busy_o !== 1'b0);
        repeat (2) begin
            @(negedge clk_i);
            #1;
            extra_req = extra_req || (data_req_o !== 1'b0) || (lsu_busy_o !== 1'b0);
        end
        total++;
        if (extra_req)
            $display("FAIL noisy_single: extra transaction seen after completion");
        else passed++;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk_i);
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10; lsu_addr_i = 32'h0000_0500;
        @(negedge clk_i);
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        #1;
        total++;
        if (lsu_busy_o !== 1'b1 || data_req_o !== 1'b0)
            $display("FAIL wait_reached: busy %b req %b expected 1 0", lsu_busy_o, data_req_o);
        else passed++;
        rst_i = 1'b1;
        #1;
        total++;
        if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0)
            $display("FAIL async_reset: busy %b req %b expected 0 0", lsu_busy_o, data_req_o);
        else passed++;
        @(negedge clk_i);
        rst_i         = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1234_5678;
        #1;
        total++;
        if (lsu_rvalid_o !== 1'b0 || lsu_busy_o !== 1'b0 || lsu_rdata_o !== 32'h0)
            $display("FAIL reset_no_pulse: rvalid %b busy %b rdata %h expected 0 0 00000000",
                     lsu_rvalid_o, lsu_busy_o, lsu_rdata_o);
        else passed++;
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
